palette_layer_compositor: RTL and testbench
===========================================

Name: palette_layer_compositor

Overview:
Sequences per-pixel lookups for several sprite/background layers through the single shared 16-entry background palette ROM. It scans the layers in priority order and skips transparent (key-colour) indices. It then drives the winning 4-bit index into the palette and registers the returned 12-bit RGB for the VGA output stage. It sits between the sprite/background address-ROM readers and the VGA colour mapper.

Parameters:
NUM_LAYERS, 3, number of requesting layers; layer 0 = background, highest index = highest priority (characters over background).
IDX_W, 4, palette index width; fixed to the palette depth of 16.
TRANSPARENT_IDX, 0, palette index treated as transparent (palette entry 0 = pure red key F00).

Ports:
Clk  in  1  system clock.
Reset_n  in  1  asynchronous active-low reset.
pixel_start  in  1  single-cycle pulse: the layer indices for a new pixel are valid.
layer_idx  in  NUM_LAYERS*IDX_W  flattened indices; layer k occupies bits [k*IDX_W +: IDX_W].
layer_en  in  NUM_LAYERS  per-layer enable; a disabled layer is never selected.
pal_index  out  IDX_W  registered index driven to the shared palette ROM.
pal_red, pal_green, pal_blue  in  4 each  combinational palette output for pal_index.
red, green, blue  out  4 each  registered composited pixel colour.
pix_valid  out  1  one-cycle pulse: red/green/blue are updated.
hit  out  1  registered with the colour; 1 if any layer was opaque.
hit_layer  out  2  winning layer number, 0 when hit=0; width covers NUM_LAYERS=3.
busy  out  1  high in SCAN and LOOKUP.
overrun  out  1  sticky; set when pixel_start arrives while busy.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; pal_index, red, green, blue, hit_layer, scan counter and latched indices/enables all 0; pix_valid, hit, busy and overrun all 0. Reset asserted mid-scan aborts the scan immediately; no pix_valid is produced for the aborted pixel.
- FSM states: IDLE, SCAN, LOOKUP.
- IDLE + pixel_start at edge T:
  - Latch layer_idx and layer_en.
  - cnt <= NUM_LAYERS-1; found <= 0; go to SCAN.
- SCAN, one layer per cycle, evaluating latched layer cnt:
  - If found=0, latched en[cnt]=1 and latched idx[cnt]!=TRANSPARENT_IDX: found <= 1, win_layer <= cnt, win_idx <= idx[cnt].
  - No early exit: always NUM_LAYERS cycles, giving fixed latency.
  - On the cycle with cnt==0: pal_index <= the winning index (including this cycle's result), or TRANSPARENT_IDX if nothing was found; go to LOOKUP. Otherwise cnt <= cnt-1.
- LOOKUP, one cycle, pal_index stable:
  - At the edge, red/green/blue <= pal_red/green/blue if found, else 0,0,0 (black).
  - hit <= found; hit_layer <= win_layer (0 if none); pix_valid <= 1; go to IDLE.
- Latency: pixel_start sampled at edge T -> pix_valid high during cycle T+NUM_LAYERS+2, for exactly 1 cycle. Throughput is one pixel per NUM_LAYERS+2 clocks; pixel_start may arrive in the same cycle pix_valid is high (state is IDLE).
- pixel_start while busy: ignored, no state change; overrun <= 1 and stays set until reset.
- Outputs hold their last values between pixels; pal_index holds in IDLE.
- Palette path is combinational; no other master drives pal_index.

Test Plan:
- Reset: Reset_n=0 for 3 cycles, with pixel_start pulsed during reset -> all outputs 0, no pix_valid, state IDLE after release.
- Priority hit: en=3'b111, idx L2=13, L1=3, L0=8; pulse at T -> pix_valid at T+5, RGB=FFF, hit=1, hit_layer=2, pal_index=13.
- Transparency fallthrough: L2=0, L1=0, L0=3, all enabled -> RGB=6DF, hit_layer=0; then L2=0, L1=14 -> RGB=6BC, hit_layer=1.
- Disabled layer: en=3'b011, L2=13, L1=0, L0=15 -> RGB=B32, hit_layer=0; all transparent or disabled -> RGB=000, hit=0.
- Back-to-back and overrun: second pulse in the pix_valid cycle -> accepted, next pix_valid 5 cycles later; a pulse at T+2 -> ignored, overrun=1, first result unchanged.
- Reset mid-scan: Reset_n low at T+2 -> no pix_valid; outputs 0; a fresh pulse after release gives the correct colour.

Source files
------------

// File: rtl/palette_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : palette_layer_compositor
//  Purpose  : Picks the highest-priority opaque layer for each pixel. The
//             winning 4-bit index is driven into the shared 16-entry palette
//             ROM, and the returned 12-bit RGB is registered for the VGA
//             colour mapper.
//  Ports    : Clk, Reset_n       - clock, asynchronous active-low reset
//             pixel_start        - one-cycle pulse, layer_idx/layer_en valid
//             layer_idx/layer_en - flattened per-layer indices and enables
//             pal_index          - registered index to the palette ROM
//             pal_red/green/blue - combinational palette data for pal_index
//             red/green/blue     - registered composited colour
//             pix_valid          - one-cycle pulse, colour updated
//             hit/hit_layer      - opaque layer found / which layer won
//             busy               - scan or lookup in progress
//             overrun            - sticky, pixel_start seen while busy
//  Revision : 1.0 - initial release
// ============================================================================
module palette_layer_compositor #(
  parameter int NUM_LAYERS      = 3,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  localparam int LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          pixel_start,
  input  logic [NUM_LAYERS*IDX_W-1:0]   layer_idx,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  output logic [IDX_W-1:0]              pal_index,
  input  logic [3:0]                    pal_red,
  input  logic [3:0]                    pal_green,
  input  logic [3:0]                    pal_blue,
  output logic [3:0]                    red,
  output logic [3:0]                    green,
  output logic [3:0]                    blue,
  output logic                          pix_valid,
  output logic                          hit,
  output logic [LAYER_W-1:0]            hit_layer,
  output logic                          busy,
  output logic                          overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_LOOKUP = 2'd2;

  localparam logic [IDX_W-1:0]   TRANSP_KEY = IDX_W'(TRANSPARENT_IDX);
  localparam logic [LAYER_W-1:0] CNT_TOP    = LAYER_W'(NUM_LAYERS - 1);

  logic [1:0]                  state_q, state_d;
  logic [LAYER_W-1:0]          cnt_q, cnt_d;
  logic                        found_q, found_d;
  logic [LAYER_W-1:0]          win_layer_q, win_layer_d;
  logic [IDX_W-1:0]            win_idx_q, win_idx_d;
  logic [NUM_LAYERS*IDX_W-1:0] layer_idx_q, layer_idx_d;
  logic [NUM_LAYERS-1:0]       layer_en_q, layer_en_d;
  logic [IDX_W-1:0]            pal_index_q, pal_index_d;
  logic [3:0]                  red_q, red_d;
  logic [3:0]                  green_q, green_d;
  logic [3:0]                  blue_q, blue_d;
  logic                        hit_q, hit_d;
  logic [LAYER_W-1:0]          hit_layer_q, hit_layer_d;
  logic                        pix_valid_q, pix_valid_d;
  logic                        overrun_q, overrun_d;

  logic [IDX_W-1:0]            cur_idx;
  logic                        cur_en;
  logic                        take;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      win_layer_q <= '0;
      win_idx_q   <= '0;
      layer_idx_q <= '0;
      layer_en_q  <= '0;
      pal_index_q <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hit_q       <= 1'b0;
      hit_layer_q <= '0;
      pix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      found_q     <= found_d;
      win_layer_q <= win_layer_d;
      win_idx_q   <= win_idx_d;
      layer_idx_q <= layer_idx_d;
      layer_en_q  <= layer_en_d;
      pal_index_q <= pal_index_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hit_q       <= hit_d;
      hit_layer_q <= hit_layer_d;
      pix_valid_q <= pix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pixel_start) state_d = S_SCAN;
      S_SCAN:   if (cnt_q == '0) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  // The layer under evaluation comes from the snapshot taken at pixel_start,
  // so the upstream readers may move on to the next pixel immediately.
  always_comb begin
    cur_idx = layer_idx_q[int'(cnt_q)*IDX_W +: IDX_W];
    cur_en  = layer_en_q[cnt_q];
    // Scanning runs from the top layer down; the first opaque, enabled layer
    // wins and later (lower) layers are still visited to keep latency fixed.
    take    = (state_q == S_SCAN) && !found_q && cur_en && (cur_idx != TRANSP_KEY);
  end

  always_comb begin
    cnt_d       = cnt_q;
    found_d     = found_q;
    win_layer_d = win_layer_q;
    win_idx_d   = win_idx_q;
    layer_idx_d = layer_idx_q;
    layer_en_d  = layer_en_q;
    pal_index_d = pal_index_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    hit_d       = hit_q;
    hit_layer_d = hit_layer_q;
    pix_valid_d = 1'b0;
    overrun_d   = overrun_q | (pixel_start && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (pixel_start) begin
          layer_idx_d = layer_idx;
          layer_en_d  = layer_en;
          cnt_d       = CNT_TOP;
          found_d     = 1'b0;
          win_layer_d = '0;
          win_idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (take) begin
          found_d     = 1'b1;
          win_layer_d = cnt_q;
          win_idx_d   = cur_idx;
        end
        if (cnt_q == '0) begin
          // Last layer: fold in this cycle's result before addressing the ROM.
          if (take)         pal_index_d = cur_idx;
          else if (found_q) pal_index_d = win_idx_q;
          else              pal_index_d = TRANSP_KEY;
        end else begin
          cnt_d = cnt_q - LAYER_W'(1);
        end
      end
      S_LOOKUP: begin
        // Nothing opaque: output black rather than the key colour.
        red_d       = found_q ? pal_red   : 4'h0;
        green_d     = found_q ? pal_green : 4'h0;
        blue_d      = found_q ? pal_blue  : 4'h0;
        hit_d       = found_q;
        hit_layer_d = found_q ? win_layer_q : '0;
        pix_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    busy      = (state_q == S_SCAN) || (state_q == S_LOOKUP);
    pal_index = pal_index_q;
    red       = red_q;
    green     = green_q;
    blue      = blue_q;
    pix_valid = pix_valid_q;
    hit       = hit_q;
    hit_layer = hit_layer_q;
    overrun   = overrun_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_palette_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_palette_layer_compositor
//  Purpose  : Directed self-checking bench for palette_layer_compositor with
//             a behavioural 16-entry palette ROM on the combinational path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_palette_layer_compositor;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pixel_start = 1'b0;
  logic [11:0] layer_idx = '0;
  logic [2:0]  layer_en = '0;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        pix_valid, hit, busy, overrun;
  logic [1:0]  hit_layer;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] pal [16];

  always #5 Clk = ~Clk;

  assign {pal_red, pal_green, pal_blue} = pal[pal_index];

  palette_layer_compositor #(
    .NUM_LAYERS(3),
    .IDX_W(4),
    .TRANSPARENT_IDX(0)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .pixel_start(pixel_start),
    .layer_idx(layer_idx),
    .layer_en(layer_en),
    .pal_index(pal_index),
    .pal_red(pal_red),
    .pal_green(pal_green),
    .pal_blue(pal_blue),
    .red(red),
    .green(green),
    .blue(blue),
    .pix_valid(pix_valid),
    .hit(hit),
    .hit_layer(hit_layer),
    .busy(busy),
    .overrun(overrun)
  );

  // Pulse one pixel, then count falling edges until pix_valid (0 = timeout).
  // The edge that samples the pulse is T; pix_valid is expected at the 4th
  // falling edge after the release edge (registered at T+4).
  task automatic drive_pixel(input logic [3:0] l2, input logic [3:0] l1,
                             input logic [3:0] l0, input logic [2:0] en,
                             output int lat);
    @(negedge Clk);
    layer_idx   = {l2, l1, l0};
    layer_en    = en;
    pixel_start = 1'b1;
    @(negedge Clk);
    pixel_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (pix_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      pixel_start = (i == 1);
      layer_idx   = {4'd13, 4'd3, 4'd8};
      layer_en    = 3'b111;
      n_checks++;
      if ({pal_index, red, green, blue, hit_layer, pix_valid, hit, busy, overrun} !== 22'h0) begin
        n_errors++;
        $display("FAIL reset_hold cycle %0d: outputs=%h expected 0", i,
                 {pal_index, red, green, blue, hit_layer, pix_valid, hit, busy, overrun});
      end
    end
    @(negedge Clk);
    pixel_start = 1'b0;
    Reset_n     = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if ({pal_index, red, green, blue, hit_layer, pix_valid, hit, busy, overrun} !== 22'h0) begin
      n_errors++;
      $display("FAIL reset_release: outputs=%h expected 0",
               {pal_index, red, green, blue, hit_layer, pix_valid, hit, busy, overrun});
    end
  endtask

  task automatic test_priority();
    int lat;
    drive_pixel(4'd13, 4'd3, 4'd8, 3'b111, lat);
    n_checks++;
    if (lat !== 4) begin
      n_errors++;
      $display("FAIL prio_latency: got %0d expected 4", lat);
    end
    n_checks++;
    if ({red, green, blue, hit, hit_layer, pal_index} !== {12'hFFF, 1'b1, 2'd2, 4'd13}) begin
      n_errors++;
      $display("FAIL prio_result: rgb=%h hit=%b layer=%0d idx=%0d expected FFF 1 2 13",
               {red, green, blue}, hit, hit_layer, pal_index);
    end
    @(negedge Clk);
    n_checks++;
    if ({pix_valid, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL prio_pulse_width: pix_valid=%b busy=%b expected 0 0", pix_valid, busy);
    end
  endtask

  task automatic test_transparency();
    int lat;
    drive_pixel(4'd0, 4'd0, 4'd3, 3'b111, lat);
    n_checks++;
    if ({lat == 4, red, green, blue, hit, hit_layer} !== {1'b1, 12'h6DF, 1'b1, 2'd0}) begin
      n_errors++;
      $display("FAIL transp_to_l0: lat=%0d rgb=%h hit=%b layer=%0d expected 4 6DF 1 0",
               lat, {red, green, blue}, hit, hit_layer);
    end
    drive_pixel(4'd0, 4'd14, 4'd3, 3'b111, lat);
    n_checks++;
    if ({lat == 4, red, green, blue, hit, hit_layer} !== {1'b1, 12'h6BC, 1'b1, 2'd1}) begin
      n_errors++;
      $display("FAIL transp_to_l1: lat=%0d rgb=%h hit=%b layer=%0d expected 4 6BC 1 1",
               lat, {red, green, blue}, hit, hit_layer);
    end
  endtask

  task automatic test_disabled();
    int lat;
    drive_pixel(4'd13, 4'd0, 4'd15, 3'b011, lat);
    n_checks++;
    if ({lat == 4, red, green, blue, hit, hit_layer, pal_index} !== {1'b1, 12'hB32, 1'b1, 2'd0, 4'd15}) begin
      n_errors++;
      $display("FAIL disabled_l2: lat=%0d rgb=%h hit=%b layer=%0d idx=%0d expected 4 B32 1 0 15",
               lat, {red, green, blue}, hit, hit_layer, pal_index);
    end
    drive_pixel(4'd0, 4'd5, 4'd0, 3'b101, lat);
    n_checks++;
    if ({lat == 4, red, green, blue, hit, hit_layer, pal_index} !== {1'b1, 12'h000, 1'b0, 2'd0, 4'd0}) begin
      n_errors++;
      $display("FAIL no_opaque: lat=%0d rgb=%h hit=%b layer=%0d idx=%0d expected 4 000 0 0 0",
               lat, {red, green, blue}, hit, hit_layer, pal_index);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_pixel(4'd13, 4'd3, 4'd8, 3'b111, lat);
    // Still in the pix_valid cycle: issue the next pixel now.
    layer_idx   = {4'd0, 4'd14, 4'd3};
    layer_en    = 3'b111;
    pixel_start = 1'b1;
    n_checks++;
    if ({lat == 4, red, green, blue} !== {1'b1, 12'hFFF}) begin
      n_errors++;
      $display("FAIL b2b_first: lat=%0d rgb=%h expected 4 FFF", lat, {red, green, blue});
    end
    @(negedge Clk);
    pixel_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (pix_valid) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if ({lat == 4, red, green, blue, hit_layer, overrun} !== {1'b1, 12'h6BC, 2'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_second: lat=%0d rgb=%h layer=%0d overrun=%b expected 4 6BC 1 0",
               lat, {red, green, blue}, hit_layer, overrun);
    end
  endtask

  task automatic test_overrun();
    int lat;
    @(negedge Clk);
    layer_idx   = {4'd13, 4'd3, 4'd8};
    layer_en    = 3'b111;
    pixel_start = 1'b1;
    @(negedge Clk);                 // T sampled
    pixel_start = 1'b0;
    @(negedge Clk);
    layer_idx   = {4'd0, 4'd0, 4'd3};
    pixel_start = 1'b1;             // sampled at T+2 while scanning
    @(negedge Clk);
    pixel_start = 1'b0;
    n_checks++;
    if ({overrun, busy} !== 2'b11) begin
      n_errors++;
      $display("FAIL overrun_set: overrun=%b busy=%b expected 1 1", overrun, busy);
    end
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (pix_valid) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if ({lat == 2, red, green, blue, hit_layer} !== {1'b1, 12'hFFF, 2'd2}) begin
      n_errors++;
      $display("FAIL overrun_result: lat=%0d rgb=%h layer=%0d expected 2 FFF 2",
               lat, {red, green, blue}, hit_layer);
    end
    repeat (6) @(negedge Clk);
    n_checks++;
    if ({overrun, pix_valid, busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL overrun_sticky: overrun=%b pix_valid=%b busy=%b expected 1 0 0",
               overrun, pix_valid, busy);
    end
  endtask

  task automatic test_reset_midscan();
    int seen;
    int lat;
    @(negedge Clk);
    layer_idx   = {4'd13, 4'd3, 4'd8};
    layer_en    = 3'b111;
    pixel_start = 1'b1;
    @(negedge Clk);
    pixel_start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({pal_index, red, green, blue, hit_layer, pix_valid, hit, busy, overrun} !== 22'h0) begin
      n_errors++;
      $display("FAIL midscan_reset: outputs=%h expected 0",
               {pal_index, red, green, blue, hit_layer, pix_valid, hit, busy, overrun});
    end
    seen = 0;
    repeat (2) begin
      @(negedge Clk);
      if (pix_valid) seen++;
    end
    Reset_n = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (pix_valid || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL midscan_no_valid: pix_valid/busy seen %0d times expected 0", seen);
    end
    drive_pixel(4'd0, 4'd14, 4'd3, 3'b111, lat);
    n_checks++;
    if ({lat == 4, red, green, blue, hit, hit_layer} !== {1'b1, 12'h6BC, 1'b1, 2'd1}) begin
      n_errors++;
      $display("FAIL midscan_fresh: lat=%0d rgb=%h hit=%b layer=%0d expected 4 6BC 1 1",
               lat, {red, green, blue}, hit, hit_layer);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal[i] = {4'(i), 4'(i), 4'(i)};
    pal[0]  = 12'hF00;
    pal[3]  = 12'h6DF;
    pal[8]  = 12'h0A5;
    pal[13] = 12'hFFF;
    pal[14] = 12'h6BC;
    pal[15] = 12'hB32;

    test_reset();
    test_priority();
    test_transparency();
    test_disabled();
    test_back_to_back();
    test_overrun();
    test_reset_midscan();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
